// File: rtl/wptr_full_status.sv
// ---------------------------------------------------------------------------
// wptr_full_status
//
// Write-side pointer and status controller for an asynchronous FIFO. Runs
// entirely in the write clock domain. It advances a binary write address and
// a registered Gray write pointer on accepted writes. It also derives full,
// almost-full, fill level and a sticky overflow flag. These are derived by
// comparing the next write pointer against the read pointer, which has
// already been synchronized into this domain.
//
// Ports
//   wclk           in   write-domain clock, rising edge
//   wrst           in   synchronous active-high reset, dominates all inputs
//   winc           in   write request, accepted only while wfull is 0
//   woverflow_clr  in   clears the sticky overflow flag
//   wq2_rptr       in   [addr:0] synchronized Gray read pointer
//   waddr          out  [addr-1:0] binary memory write address
//   wptr           out  [addr:0] registered Gray write pointer
//   wfull          out  registered full flag
//   walmost_full   out  registered flag, level >= afull_level
//   wlevel         out  [addr:0] registered fill level, 0..2**addr
//   woverflow      out  sticky flag, a write was attempted while full
// ---------------------------------------------------------------------------
module wptr_full_status #(
    parameter int addr        = 4,
    parameter int afull_level = 14
) (
    input  logic            wclk,
    input  logic            wrst,
    input  logic            winc,
    input  logic            woverflow_clr,
    input  logic [addr:0]   wq2_rptr,
    output logic [addr-1:0] waddr,
    output logic [addr:0]   wptr,
    output logic            wfull,
    output logic            walmost_full,
    output logic [addr:0]   wlevel,
    output logic            woverflow
);

    localparam logic [addr:0] AFULL_LVL = (addr+1)'(afull_level);

    logic [addr:0] wbin_q,  wbin_d;
    logic [addr:0] wptr_q,  wptr_d;
    logic          wfull_q, wfull_d;
    logic          wafull_q, wafull_d;
    logic [addr:0] wlevel_q, wlevel_d;
    logic          wovf_q,  wovf_d;

    logic          winc_ok;
    logic [addr:0] rbin_s;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or
    // above it. Written per bit so no bit of the vector depends on another.
    generate
        for (genvar gi = 0; gi <= addr; gi++) begin : g_rbin
            assign rbin_s[gi] = ^wq2_rptr[addr:gi];
        end
    endgenerate

    // A write while full is dropped entirely; the pointer does not move.
    assign winc_ok = winc & ~wfull_q;

    always_comb begin
        wbin_d   = wbin_q + {{addr{1'b0}}, winc_ok};
        wptr_d   = (wbin_d >> 1) ^ wbin_d;
        // Full when the next Gray pointer equals the read pointer with its
        // two MSBs inverted: one full lap ahead, correct across wrap-around.
        wfull_d  = (wptr_d == {~wq2_rptr[addr:addr-1], wq2_rptr[addr-2:0]});
        wlevel_d = wbin_d - rbin_s;
        wafull_d = (wlevel_d >= AFULL_LVL);
        // Setting has priority over clearing in the same cycle.
        if (winc & wfull_q) begin
            wovf_d = 1'b1;
        end else if (woverflow_clr) begin
            wovf_d = 1'b0;
        end else begin
            wovf_d = wovf_q;
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wlevel_q <= '0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wlevel_q <= wlevel_d;
            wovf_q   <= wovf_d;
        end
    end

    assign waddr        = wbin_q[addr-1:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = wafull_q;
    assign wlevel       = wlevel_q;
    assign woverflow    = wovf_q;

endmodule

// File: tb/tb_wptr_full_status.sv
// ---------------------------------------------------------------------------
// tb_wptr_full_status
//
// Scoreboard bench for wptr_full_status (addr=4, afull_level=14). A driver
// applies one transaction per clock. It also computes the expected post-edge
// outputs from a count-based reference model and queues them. A monitor pops
// one entry after every rising edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_wptr_full_status;

    localparam int ADDR  = 4;
    localparam int DEPTH = 1 << ADDR;
    localparam int PMOD  = 2 * DEPTH;
    localparam int AFULL = 14;

    typedef struct packed {
        logic [ADDR-1:0] waddr;
        logic [ADDR:0]   wptr;
        logic            wfull;
        logic            wafull;
        logic [ADDR:0]   wlevel;
        logic            wovf;
    } exp_t;

    logic            wclk = 1'b0;
    logic            wrst = 1'b1;
    logic            winc = 1'b0;
    logic            woverflow_clr = 1'b0;
    logic [ADDR:0]   wq2_rptr = '0;
    logic [ADDR-1:0] waddr;
    logic [ADDR:0]   wptr;
    logic            wfull;
    logic            walmost_full;
    logic [ADDR:0]   wlevel;
    logic            woverflow;

    wptr_full_status #(.addr(ADDR), .afull_level(AFULL)) dut (
        .wclk          (wclk),
        .wrst          (wrst),
        .winc          (winc),
        .woverflow_clr (woverflow_clr),
        .wq2_rptr      (wq2_rptr),
        .waddr         (waddr),
        .wptr          (wptr),
        .wfull         (wfull),
        .walmost_full  (walmost_full),
        .wlevel        (wlevel),
        .woverflow     (woverflow)
    );

    always #5 wclk = ~wclk;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   txn    = 0;

    // Reference model: total accepted writes (mod 2*depth) plus flags.
    int m_wcnt = 0;
    bit m_full = 0;
    bit m_ovf  = 0;
    int rcnt   = 0;

    function automatic logic [ADDR:0] to_gray(input int b);
        return (ADDR+1)'(b ^ (b >> 1));
    endfunction

    // Decode a Gray code by searching for the count that produces it.
    function automatic int from_gray(input logic [ADDR:0] g);
        for (int b = 0; b < PMOD; b++)
            if (to_gray(b) == g) return b;
        return 0;
    endfunction

    task automatic step(input bit rst, input bit inc, input bit clr,
                        input int rc);
        exp_t e;
        int   lvl;
        @(negedge wclk);
        wrst          = rst;
        winc          = inc;
        woverflow_clr = clr;
        wq2_rptr      = to_gray(rc);
        if (rst) begin
            m_wcnt = 0;
            m_full = 0;
            m_ovf  = 0;
            lvl    = 0;
        end else begin
            if (inc && m_full) m_ovf = 1;
            else if (clr)      m_ovf = 0;
            if (inc && !m_full) m_wcnt = (m_wcnt + 1) % PMOD;
            lvl    = (m_wcnt - from_gray(to_gray(rc)) + PMOD) % PMOD;
            m_full = (lvl == DEPTH);
        end
        e.waddr  = ADDR'(m_wcnt % DEPTH);
        e.wptr   = to_gray(m_wcnt);
        e.wfull  = m_full;
        e.wafull = (lvl >= AFULL);
        e.wlevel = (ADDR+1)'(lvl);
        e.wovf   = m_ovf;
        exp_q.push_back(e);
    endtask

    // Monitor: one comparison per clock edge that has a queued expectation.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge wclk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {waddr, wptr, wfull, walmost_full, wlevel, woverflow};
                checks++;
                txn++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL txn%0d outputs: got waddr=%0d wptr=%b full=%b af=%b lvl=%0d ovf=%b, need waddr=%0d wptr=%b full=%b af=%b lvl=%0d ovf=%b",
                             txn, got.waddr, got.wptr, got.wfull, got.wafull, got.wlevel, got.wovf,
                             e.waddr, e.wptr, e.wfull, e.wafull, e.wlevel, e.wovf);
                end else begin
                    $display("txn%0d ok: waddr=%0d wptr=%b full=%b af=%b lvl=%0d ovf=%b",
                             txn, got.waddr, got.wptr, got.wfull, got.wafull, got.wlevel, got.wovf);
                end
            end
        end
    end

    initial begin
        int lvl;
        // Reset held with winc active and a nonzero read pointer.
        for (int i = 0; i < 3; i++) step(1, 1, 0, 4);
        // Fill 16 slots against an idle reader.
        rcnt = 0;
        for (int i = 0; i < 16; i++) step(0, 1, 0, rcnt);
        // Overflow: writes while full, clear alone, clear racing a set.
        step(0, 1, 0, rcnt);
        step(0, 1, 0, rcnt);
        step(0, 0, 1, rcnt);
        step(0, 1, 1, rcnt);
        // Drain visibility: reader reaches binary 4.
        rcnt = 4;
        step(0, 0, 0, rcnt);
        step(0, 1, 0, rcnt);
        step(0, 1, 0, rcnt);
        // Wrap: reader trails the post-write count by 2 over 40 writes.
        for (int i = 0; i < 40; i++) begin
            rcnt = (m_wcnt + 1 - 2 + PMOD) % PMOD;
            step(0, 1, 0, rcnt);
        end
        // Mid-operation reset at level 9.
        rcnt = (m_wcnt - 8 + PMOD) % PMOD;
        step(0, 1, 0, rcnt);
        rcnt = 0;
        step(1, 1, 0, rcnt);
        step(0, 1, 0, rcnt);
        // Random traffic: slow reader first to reach full, then faster.
        for (int i = 0; i < 300; i++) begin
            bit inc;
            bit clr;
            bit rst;
            inc = ($urandom % 4) != 0;
            clr = ($urandom % 8) == 0;
            rst = ($urandom % 120) == 0;
            lvl = (m_wcnt - rcnt + PMOD) % PMOD;
            if (lvl > 0 && ($urandom % ((i < 150) ? 6 : 2)) == 0)
                rcnt = (rcnt + 1 + ($urandom % ((lvl < 3) ? lvl : 3))) % PMOD;
            if (rst) rcnt = 0;
            step(rst, inc, clr, rcnt);
        end
        step(0, 0, 0, rcnt);
        @(negedge wclk);
        @(negedge wclk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, need 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
